// File: rtl/adc_comp_pkg.sv
// Shared constants and sample type for the ADC hysteresis comparator slice.
package adc_comp_pkg;

    localparam int unsigned ADC_W     = 12;
    localparam int unsigned MID       = 2048;
    localparam int unsigned HYST      = 16;
    localparam int unsigned AVG_SHIFT = 6;
    localparam int unsigned PER_W     = 16;

    typedef logic [ADC_W-1:0] adc_sample_t;

endpackage

// File: rtl/adc_comp_if.sv
// Sample-in / square-wave-out bundle between the analog front-end and the PLL side.
interface adc_comp_if;
    import adc_comp_pkg::*;

    logic             swipt_alive;
    adc_sample_t      adc;
    logic             adc_comp;
    logic             adc_rise;
    logic [PER_W-1:0] period;
    logic             period_valid;

    modport master (
        output swipt_alive,
        output adc,
        input  adc_comp,
        input  adc_rise,
        input  period,
        input  period_valid
    );

    modport slave (
        input  swipt_alive,
        input  adc,
        output adc_comp,
        output adc_rise,
        output period,
        output period_valid
    );

endinterface

// File: rtl/adc_comp_period.sv
// Rise detection on the comparator output and saturating rise-to-rise period counter.
module adc_comp_period
    import adc_comp_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_cmp,
    input  logic             i_alive,
    output logic             o_rise,
    output logic [PER_W-1:0] o_period,
    output logic             o_period_valid
);

    localparam logic [PER_W-1:0] CNT_MAX = '1;

    logic             r_cmp_d;
    logic             r_seen;
    logic             r_valid;
    logic [PER_W-1:0] r_per_cnt;
    logic [PER_W-1:0] r_period;
    logic             w_rise;
    logic [PER_W-1:0] w_cnt_inc;

    // Both operands are registers, so the pulse is glitch-free and lasts one cycle.
    assign w_rise    = i_cmp & ~r_cmp_d;
    assign w_cnt_inc = (r_per_cnt == CNT_MAX) ? CNT_MAX : r_per_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_cmp_d   <= 1'b0;
            r_seen    <= 1'b0;
            r_valid   <= 1'b0;
            r_per_cnt <= '0;
            r_period  <= '0;
        end else begin
            r_cmp_d <= i_cmp;
            if (!i_alive) begin
                r_per_cnt <= '0;
                r_seen    <= 1'b0;
                r_valid   <= 1'b0;
            end else if (w_rise) begin
                r_per_cnt <= '0;
                r_seen    <= 1'b1;
                if (r_seen) begin
                    r_period <= w_cnt_inc;
                    r_valid  <= 1'b1;
                end
            end else begin
                r_per_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_rise         = w_rise;
    assign o_period       = r_period;
    assign o_period_valid = r_valid;

endmodule

// File: rtl/adc_comp.sv
// Registered hysteresis comparator turning ADC samples into a square wave for PLL acquisition.
// Define ADC_COMP_DCTRACK_EN to replace the fixed midscale threshold with a tracked DC level.
module adc_comp
    import adc_comp_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    adc_comp_if.slave  io_bus
);

    localparam int unsigned CMP_W = ADC_W + 2;
    localparam logic signed [CMP_W-1:0] HYST_S = CMP_W'(HYST);

    adc_sample_t              r_adc_q;
    logic                     r_cmp;
    logic                     w_cmp_nxt;
    adc_sample_t              w_thr_u;
    logic signed [CMP_W-1:0]  w_q;
    logic signed [CMP_W-1:0]  w_thr;
    logic signed [CMP_W-1:0]  w_hi;
    logic signed [CMP_W-1:0]  w_lo;

`ifdef ADC_COMP_DCTRACK_EN
    localparam int unsigned ACC_W = ADC_W + AVG_SHIFT;
    localparam logic [ACC_W-1:0] ACC_RST = ACC_W'(MID) << AVG_SHIFT;

    logic [ACC_W-1:0] r_acc;

    // Intermediate sum may wrap mod 2^ACC_W; the settled result always fits.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_acc <= ACC_RST;
        end else if (io_bus.swipt_alive) begin
            r_acc <= r_acc + ACC_W'(r_adc_q) - (r_acc >> AVG_SHIFT);
        end
    end

    assign w_thr_u = r_acc[ACC_W-1:AVG_SHIFT];
`else
    assign w_thr_u = adc_sample_t'(MID);
`endif

    // Two guard bits keep thr +/- HYST from wrapping at the rails.
    assign w_q   = signed'({2'b00, r_adc_q});
    assign w_thr = signed'({2'b00, w_thr_u});
    assign w_hi  = w_thr + HYST_S;
    assign w_lo  = w_thr - HYST_S;

    always_comb begin
        w_cmp_nxt = r_cmp;
        if (!io_bus.swipt_alive) begin
            w_cmp_nxt = 1'b0;
        end else if (!r_cmp && (w_q > w_hi)) begin
            w_cmp_nxt = 1'b1;
        end else if (r_cmp && (w_q < w_lo)) begin
            w_cmp_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_adc_q <= '0;
            r_cmp   <= 1'b0;
        end else begin
            r_adc_q <= io_bus.adc;
            r_cmp   <= w_cmp_nxt;
        end
    end

    assign io_bus.adc_comp = r_cmp;

    adc_comp_period u_period (
        .clk            (clk),
        .nrst           (nrst),
        .i_cmp          (r_cmp),
        .i_alive        (io_bus.swipt_alive),
        .o_rise         (io_bus.adc_rise),
        .o_period       (io_bus.period),
        .o_period_valid (io_bus.period_valid)
    );

endmodule

// File: tb/tb_adc_comp.sv
// Directed bench for adc_comp in its default build (fixed midscale threshold).
module tb_adc_comp;
    import adc_comp_pkg::*;

    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    adc_comp_if bus ();

    adc_comp dut (
        .clk    (clk),
        .nrst   (nrst),
        .io_bus (bus)
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample, advance one clock, settle just past the edge.
    task automatic cyc(input int unsigned a, input logic al);
        bus.adc         = adc_sample_t'(a);
        bus.swipt_alive = al;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned av [7];
        logic        ec [7];
        logic        er [7];
        logic        exp_comp;
        logic        exp_rise;
        int unsigned a;

        av = '{2048, 2064, 2065, 2040, 2032, 2031, 2031};
        ec = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        nrst            = 1'b1;
        bus.adc         = '1;
        bus.swipt_alive = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cyc(4095, 1'b1);
            check("rst_comp",  32'(bus.adc_comp),     32'd0);
            check("rst_rise",  32'(bus.adc_rise),     32'd0);
            check("rst_period",32'(bus.period),       32'd0);
            check("rst_valid", 32'(bus.period_valid), 32'd0);
        end
        nrst = 1'b0;

        // Hysteresis boundaries: 2064 and 2032 hold, 2065 rises, 2031 falls.
        for (int i = 0; i < 7; i++) begin
            cyc(av[i], 1'b1);
            check("hyst_comp",  32'(bus.adc_comp),     32'(ec[i]));
            check("hyst_rise",  32'(bus.adc_rise),     32'(er[i]));
            check("hyst_valid", 32'(bus.period_valid), 32'd0);
            check("hyst_period",32'(bus.period),       32'd0);
        end

        // Square wave of period 10 with a one-cycle link drop at k=43.
        for (int k = 0; k <= 62; k++) begin
            a = ((k % 10) < 5) ? 3000 : 1000;
            cyc(a, (k != 43));
            if (k == 0)       exp_comp = 1'b0;
            else if (k == 43) exp_comp = 1'b0;
            else              exp_comp = (((k - 1) % 10) < 5);
            exp_rise = ((k % 10) == 1) || (k == 44);
            check("sq_comp", 32'(bus.adc_comp), 32'(exp_comp));
            check("sq_rise", 32'(bus.adc_rise), 32'(exp_rise));
            if (k == 12) check("sq_period12", 32'(bus.period), 32'd10);
            if (k == 39) begin
                check("sq_period39", 32'(bus.period),       32'd10);
                check("sq_valid39",  32'(bus.period_valid), 32'd1);
            end
            if (k == 43) begin
                check("loss_period", 32'(bus.period),       32'd10);
                check("loss_valid",  32'(bus.period_valid), 32'd0);
            end
            if (k == 51) check("relock_valid51", 32'(bus.period_valid), 32'd0);
            if (k == 52) begin
                check("relock_period52", 32'(bus.period),       32'd7);
                check("relock_valid52",  32'(bus.period_valid), 32'd1);
            end
            if (k == 62) check("relock_period62", 32'(bus.period), 32'd10);
        end

        // Constant high long enough for the period counter to saturate.
        for (int i = 0; i < 66000; i++) cyc(3000, 1'b1);
        check("sat_comp",   32'(bus.adc_comp),     32'd1);
        check("sat_period", 32'(bus.period),       32'd10);
        check("sat_valid",  32'(bus.period_valid), 32'd1);
        cyc(1000, 1'b1);
        check("sat_hold_comp", 32'(bus.adc_comp), 32'd1);
        cyc(3000, 1'b1);
        check("sat_fall_comp", 32'(bus.adc_comp), 32'd0);
        cyc(3000, 1'b1);
        check("sat_rise_comp", 32'(bus.adc_comp), 32'd1);
        check("sat_rise",      32'(bus.adc_rise), 32'd1);
        cyc(3000, 1'b1);
        check("sat_period_max", 32'(bus.period),       32'd65535);
        check("sat_valid_max",  32'(bus.period_valid), 32'd1);

        nrst = 1'b1;
        cyc(3000, 1'b1);
        check("rst2_comp",   32'(bus.adc_comp),     32'd0);
        check("rst2_rise",   32'(bus.adc_rise),     32'd0);
        check("rst2_period", 32'(bus.period),       32'd0);
        check("rst2_valid",  32'(bus.period_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
